// File: rtl/capture_pkg.sv
// Shared types and defaults for the capture sequencer.
package capture_pkg;
  typedef enum logic [2:0] {IDLE, PRETRIG, ARMED, POSTTRIG, DONE} cap_state_t;
  localparam int DEPTH_DEF = 512;
endpackage

// File: rtl/capture_ctrl_if.sv
// Handshake bundle between the host/trigger side and the capture sequencer.
interface capture_ctrl_if
  import capture_pkg::*;
#(
  parameter int ADDR_W = $clog2(DEPTH_DEF)
);
  logic              run;
  logic              clr_capture_done;
  logic              wrt_smpl;
  logic [ADDR_W-1:0] trig_pos;
  logic              triggered;
  logic              armed;
  logic              set_capture_done;
  logic              capture_done;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [ADDR_W-1:0] trig_addr;

  modport master (
    output run, clr_capture_done, wrt_smpl, trig_pos, triggered,
    input  armed, set_capture_done, capture_done, we, waddr, trig_addr
  );
  modport slave (
    input  run, clr_capture_done, wrt_smpl, trig_pos, triggered,
    output armed, set_capture_done, capture_done, we, waddr, trig_addr
  );
endinterface

// File: rtl/capture_ctrl_addr_cnt.sv
// Circular write-address counter; wraps DEPTH-1 -> 0 so DEPTH need not be a power of two.
module circ_addr_cnt #(
  parameter int DEPTH  = 512,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              inc,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] addr_nxt
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  logic [ADDR_W-1:0] r_addr;

  assign addr     = r_addr;
  assign addr_nxt = (r_addr == LAST) ? '0 : r_addr + ADDR_W'(1);

  always_ff @(posedge clk) begin
    if (rst)      r_addr <= '0;
    else if (clr) r_addr <= '0;
    else if (inc) r_addr <= addr_nxt;
  end
endmodule

// File: rtl/capture_ctrl.sv
// Sequences one acquisition into the circular sample RAM around a trigger:
// fill the pre-trigger window, arm, then count post-trigger samples to DONE.
module capture_ctrl
  import capture_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input logic           clk,
  input logic           rst,
  capture_ctrl_if.slave bus
);
  localparam logic [ADDR_W-1:0] TP_MAX = ADDR_W'(DEPTH - 1);

  cap_state_t        r_state;
  logic [ADDR_W-1:0] r_tp;
  logic [ADDR_W-1:0] r_pre_cnt;
  logic [ADDR_W-1:0] r_post_cnt;
  logic [ADDR_W-1:0] r_trig_addr;
  logic              r_set_done;

  logic              w_active;
  logic              w_we;
  logic              w_start;
  logic              w_go_done;
  logic [ADDR_W-1:0] w_tp_in;
  logic [ADDR_W-1:0] w_pre_last;
  logic [ADDR_W-1:0] w_waddr;
  logic [ADDR_W-1:0] w_waddr_nxt;

  // Clamp keeps at least one pre-trigger sample in the buffer.
  assign w_tp_in    = (bus.trig_pos > TP_MAX) ? TP_MAX : bus.trig_pos;
  assign w_pre_last = TP_MAX - r_tp;
  assign w_active   = (r_state == PRETRIG) || (r_state == ARMED) || (r_state == POSTTRIG);
  assign w_we       = w_active && bus.wrt_smpl;
  assign w_start    = (r_state == IDLE) && bus.run;
  assign w_go_done  = ((r_state == ARMED) && bus.triggered && (r_tp == '0)) ||
                      ((r_state == POSTTRIG) && w_we && (r_post_cnt == r_tp - ADDR_W'(1)));

  circ_addr_cnt #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_addr (
    .clk      (clk),
    .rst      (rst),
    .clr      (w_start),
    .inc      (w_we),
    .addr     (w_waddr),
    .addr_nxt (w_waddr_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_tp        <= '0;
      r_pre_cnt   <= '0;
      r_post_cnt  <= '0;
      r_trig_addr <= '0;
      r_set_done  <= 1'b0;
    end else begin
      r_set_done <= w_go_done;
      case (r_state)
        IDLE: if (bus.run) begin
          r_state   <= PRETRIG;
          r_pre_cnt <= '0;
          r_tp      <= w_tp_in;
        end
        PRETRIG: if (w_we) begin
          r_pre_cnt <= r_pre_cnt + ADDR_W'(1);
          if (r_pre_cnt == w_pre_last) r_state <= ARMED;
        end
        ARMED: if (bus.triggered) begin
          // A write in the trigger cycle still belongs to the pre-trigger window.
          r_trig_addr <= w_we ? w_waddr_nxt : w_waddr;
          r_post_cnt  <= '0;
          r_state     <= (r_tp == '0) ? DONE : POSTTRIG;
        end
        POSTTRIG: if (w_we) begin
          r_post_cnt <= r_post_cnt + ADDR_W'(1);
          if (w_go_done) r_state <= DONE;
        end
        DONE: if (bus.clr_capture_done) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.armed            = (r_state == ARMED);
  assign bus.capture_done     = (r_state == DONE);
  assign bus.set_capture_done = r_set_done;
  assign bus.we               = w_we;
  assign bus.waddr            = w_waddr;
  assign bus.trig_addr        = r_trig_addr;
endmodule
